// File: rtl/pipelined_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead ALU: op encodings and group width.
package pipelined_cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  localparam int unsigned GRP_W = 8;

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit adder: 8-bit groups with generate/propagate lookahead between groups.
module cla_segment
  import pipelined_cla_pkg::*;
#(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  localparam int unsigned NGRP = SEG / GRP_W;

  logic [SEG-1:0]  g;
  logic [SEG-1:0]  p;
  logic [SEG-1:0]  c;
  logic [NGRP-1:0] gg;
  logic [NGRP-1:0] gp;
  logic [NGRP:0]   gc;
  logic            term;

  assign g = a & b;
  assign p = a ^ b;

  // group generate/propagate from the eight bits of each group
  always_comb begin
    gg = '0;
    gp = '1;
    for (int j = 0; j < int'(NGRP); j++) begin
      for (int i = 0; i < int'(GRP_W); i++) begin
        gg[j] = g[j*GRP_W+i] | (p[j*GRP_W+i] & gg[j]);
        gp[j] = gp[j] & p[j*GRP_W+i];
      end
    end
  end

  // group carries in flattened sum-of-products form, no ripple between groups
  always_comb begin
    gc    = '0;
    gc[0] = cin;
    term  = 1'b0;
    for (int j = 0; j < int'(NGRP); j++) begin
      term = cin;
      for (int m = 0; m <= j; m++) begin
        term = term & gp[m];
      end
      gc[j+1] = term;
      for (int m = 0; m <= j; m++) begin
        term = gg[m];
        for (int n = m + 1; n <= j; n++) begin
          term = term & gp[n];
        end
        gc[j+1] = gc[j+1] | term;
      end
    end
  end

  // bit carries inside each group start from that group's lookahead carry
  always_comb begin
    c = '0;
    for (int j = 0; j < int'(NGRP); j++) begin
      c[j*GRP_W] = gc[j];
      for (int i = 0; i < int'(GRP_W) - 1; i++) begin
        c[j*GRP_W+i+1] = g[j*GRP_W+i] | (p[j*GRP_W+i] & c[j*GRP_W+i]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NGRP];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla.sv
// Pipelined ADD/SUB/AND/OR unit, one SEG-bit segment per stage, valid/ready handshake.
// Optional macro PIPELINED_CLA_FLAGS_EN enables the ovf and zero flags.
module pipelined_cla
  import pipelined_cla_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSTG = WIDTH / SEG;

  logic             en;
  op_t              op_dec;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign op_dec   = op_t'(op);

  // subtraction is a + ~b + 1; logic ops see the raw operands and no carry
  assign b_eff   = (op_dec == OP_SUB) ? ~b : b;
  assign cin_eff = (op_dec == OP_SUB) || ((op_dec == OP_ADD) && cin);

  for (genvar k = 0; k < NSTG; k++) begin : stg
    localparam int unsigned LO = k * SEG;
    localparam int unsigned IW = WIDTH - LO;

    logic [IW-1:0]     a_in;
    logic [IW-1:0]     b_in;
    logic              c_in;
    logic              v_in;
    op_t               o_in;
    logic [LO+SEG-1:0] res_in;
    logic [SEG-1:0]    seg_sum;
    logic [SEG-1:0]    seg_res;
    logic              seg_cout;
    logic              seg_cmsb;

    if (k == 0) begin : src
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = cin_eff;
      assign v_in   = in_valid;
      assign o_in   = op_dec;
      assign res_in = seg_res;
    end else begin : src
      assign a_in   = stg[k-1].rem.a_q;
      assign b_in   = stg[k-1].rem.b_q;
      assign c_in   = stg[k-1].rem.carry_q;
      assign v_in   = stg[k-1].rem.valid_q;
      assign o_in   = stg[k-1].rem.op_q;
      assign res_in = {seg_res, stg[k-1].rem.res_q};
    end

    cla_segment #(.SEG(SEG)) u_seg (
      .a    (a_in[SEG-1:0]),
      .b    (b_in[SEG-1:0]),
      .cin  (c_in),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    always_comb begin
      case (o_in)
        OP_AND:  seg_res = a_in[SEG-1:0] & b_in[SEG-1:0];
        OP_OR:   seg_res = a_in[SEG-1:0] | b_in[SEG-1:0];
        default: seg_res = seg_sum;
      endcase
    end

    if (k < NSTG - 1) begin : rem
      // upper operand bits ride along skewed; finished result bits accumulate low
      logic [IW-SEG-1:0] a_q;
      logic [IW-SEG-1:0] b_q;
      logic [LO+SEG-1:0] res_q;
      logic              carry_q;
      logic              valid_q;
      op_t               op_q;
      logic              unused_cmsb;

      assign unused_cmsb = seg_cmsb;

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_q <= 1'b0;
        end else if (en) begin
          valid_q <= v_in;
        end
      end

      always_ff @(posedge clock) begin
        if (en) begin
          a_q     <= a_in[IW-1:SEG];
          b_q     <= b_in[IW-1:SEG];
          res_q   <= res_in;
          carry_q <= seg_cout;
          op_q    <= o_in;
        end
      end
    end else begin : tail
      logic arith;

      assign arith = (o_in == OP_ADD) || (o_in == OP_SUB);

      always_ff @(posedge clock) begin
        if (reset) begin
          out_valid <= 1'b0;
          result    <= '0;
          cout      <= 1'b0;
        end else if (en) begin
          out_valid <= v_in;
          result    <= res_in;
          cout      <= arith & seg_cout;
        end
      end

`ifdef PIPELINED_CLA_FLAGS_EN
      always_ff @(posedge clock) begin
        if (reset) begin
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (en) begin
          ovf  <= arith & (seg_cmsb ^ seg_cout);
          zero <= ~|res_in;
        end
      end
`else
      logic unused_cmsb;

      assign unused_cmsb = seg_cmsb;
      assign ovf         = 1'b0;
      assign zero        = 1'b0;
`endif
    end
  end

endmodule
